// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_if.sv
// Request/result bundle between a requester (master) and the converter core (slave).
interface bin_to_bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);
    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/bin_to_bcd_core.sv
// Sequential double-dabble converter core. Define BIN_TO_BCD_BLANK_EN to blank
// leading zero digits with BLANK_CODE (units digit is never blanked).
module bin_to_bcd_core
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    bin_to_bcd_if.slave   bus
);
    localparam int SCR_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   shift_reg;
    logic [SCR_W-1:0]   scratch_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [SCR_W-1:0]   bcd_reg;

    logic [SCR_W-1:0]   adj;
    logic [SCR_W-1:0]   scratch_shifted;
    logic [SCR_W-1:0]   bcd_fmt;
    logic               last_shift;
    logic               unused_msb;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit    (scratch_reg[gi*DIGIT_W +: DIGIT_W]),
                .adjusted (adj[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // The top scratch bit always shifts out as zero given 10^DIGITS > 2^WIDTH-1.
    assign unused_msb      = adj[SCR_W-1];
    assign scratch_shifted = {adj[SCR_W-2:0], shift_reg[WIDTH-1]};
    assign last_shift      = (count_reg == CNT_W'(1));

    always_comb begin
        logic lead;
        bcd_fmt = scratch_shifted;
        lead    = 1'b1;
`ifdef BIN_TO_BCD_BLANK_EN
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (lead && (scratch_shifted[k*DIGIT_W +: DIGIT_W] == '0)) begin
                bcd_fmt[k*DIGIT_W +: DIGIT_W] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
`else
        lead = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy = (state_reg != IDLE);
        bus.done = (state_reg == DONE);
    end

    assign bus.bcd_out = bcd_reg;

    // The result is latched on the final shift edge so it is valid in the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            scratch_reg <= '0;
            count_reg   <= '0;
            bcd_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        shift_reg   <= bus.bin_in;
                        scratch_reg <= '0;
                        count_reg   <= CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    scratch_reg <= scratch_shifted;
                    shift_reg   <= shift_reg << 1;
                    count_reg   <= count_reg - CNT_W'(1);
                    if (last_shift) begin
                        bcd_reg <= bcd_fmt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/bin_to_bcd.sv
// Binary-to-BCD converter top: plain ports wrapped onto the converter bundle.
module bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out
);
    bin_to_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    assign bus.start  = start;
    assign bus.bin_in = bin_in;
    assign busy       = bus.busy;
    assign done       = bus.done;
    assign bcd_out    = bus.bcd_out;

    bin_to_bcd_core #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
endmodule
